// File: rtl/exalu_cbc_sequencer_pkg.sv
// rtl/exalu_cbc_sequencer_pkg.sv - exalu op codes and CBC sequencer state encoding
package exalu_cbc_sequencer_pkg;

  localparam logic [2:0] ALU_ADD    = 3'h0;
  localparam logic [2:0] ALU_AESENC = 3'h1;
  localparam logic [2:0] ALU_AESDEC = 3'h2;
  localparam logic [2:0] ALU_XOR    = 3'h7;

  typedef enum logic [3:0] {
    S_IDLE,
    S_LOAD,
    S_PRE_XOR,
    S_AES_ISSUE,
    S_AES_WAIT_HI,
    S_AES_WAIT_LO,
    S_AES_DONE,
    S_POST_XOR,
    S_OUTPUT,
    S_FINISH
  } seqState_t;

endpackage

// File: rtl/exalu_cbc_sequencer.sv
// rtl/exalu_cbc_sequencer.sv - AES-128-CBC multi-block sequencer driving exalu
module exalu_cbc_sequencer
  import exalu_cbc_sequencer_pkg::*;
#(
  parameter int NB_W         = 16,
  parameter int BUSY_TIMEOUT = 64
) (
  input  logic            clock,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic            cmd_decrypt,
  input  logic [127:0]    cmd_key,
  input  logic [127:0]    cmd_iv,
  input  logic [NB_W-1:0] cmd_nblocks,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [127:0]    in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [127:0]    out_data,
  output logic            out_last,
  output logic            done,
  output logic            err,
  output logic            alu_we,
  output logic [2:0]      alu_control,
  output logic [255:0]    alu_d1,
  output logic [255:0]    alu_d2,
  input  logic [255:0]    alu_out,
  input  logic            alu_busy
);

  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  seqState_t       state;
  logic            isDec;
  logic [127:0]    key;
  logic [127:0]    chain;
  logic [127:0]    blk;
  logic [127:0]    aluD1Lo;
  logic [127:0]    aluD2Lo;
  logic [NB_W-1:0] remaining;
  logic [TW-1:0]   timer;
  logic [127:0]    aluLo;
  logic            unusedAluHi;

  // exalu operands live in the low half only; the upper half of its result is never consumed
  assign alu_d1      = {128'b0, aluD1Lo};
  assign alu_d2      = {128'b0, aluD2Lo};
  assign aluLo       = alu_out[127:0];
  assign unusedAluHi = ^alu_out[255:128];

  // command sequencer: every output is registered and set on entry to the state that owns it
  always_ff @(posedge clock) begin
    if (reset) begin
      state       <= S_IDLE;
      cmd_ready   <= 1'b1;
      in_ready    <= 1'b0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      out_data    <= '0;
      done        <= 1'b0;
      err         <= 1'b0;
      alu_we      <= 1'b0;
      alu_control <= ALU_ADD;
      aluD1Lo     <= '0;
      aluD2Lo     <= '0;
      isDec       <= 1'b0;
      key         <= '0;
      chain       <= '0;
      blk         <= '0;
      remaining   <= '0;
      timer       <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            isDec     <= cmd_decrypt;
            key       <= cmd_key;
            chain     <= cmd_iv;
            remaining <= cmd_nblocks;
            err       <= 1'b0;
            cmd_ready <= 1'b0;
            if (cmd_nblocks == '0) begin
              state <= S_FINISH;
              done  <= 1'b1;
            end else begin
              state    <= S_LOAD;
              in_ready <= 1'b1;
            end
          end
        end
        S_LOAD: begin
          if (in_valid) begin
            blk         <= in_data;
            in_ready    <= 1'b0;
            aluD1Lo     <= in_data;
            aluD2Lo     <= isDec ? key : chain;
            alu_control <= isDec ? ALU_AESDEC : ALU_XOR;
            alu_we      <= isDec;
            state       <= isDec ? S_AES_ISSUE : S_PRE_XOR;
          end
        end
        S_PRE_XOR: begin
          // XOR is combinational in exalu, so the whitened block is ready this cycle
          blk         <= aluLo;
          aluD1Lo     <= aluLo;
          aluD2Lo     <= key;
          alu_control <= ALU_AESENC;
          alu_we      <= 1'b1;
          state       <= S_AES_ISSUE;
        end
        S_AES_ISSUE: begin
          timer <= '0;
          state <= S_AES_WAIT_HI;
        end
        S_AES_WAIT_HI: begin
          if (alu_busy) begin
            state <= S_AES_WAIT_LO;
          end else if (timer == TW'(BUSY_TIMEOUT - 1)) begin
            alu_we <= 1'b0;
            err    <= 1'b1;
            done   <= 1'b1;
            state  <= S_FINISH;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        S_AES_WAIT_LO: begin
          if (!alu_busy) state <= S_AES_DONE;
        end
        S_AES_DONE: begin
          // alu_we is still high here, which returns exalu from Fin to Calc
          alu_we <= 1'b0;
          if (isDec) begin
            aluD1Lo     <= aluLo;
            aluD2Lo     <= chain;
            alu_control <= ALU_XOR;
            state       <= S_POST_XOR;
          end else begin
            chain     <= aluLo;
            out_data  <= aluLo;
            out_valid <= 1'b1;
            out_last  <= (remaining == NB_W'(1));
            state     <= S_OUTPUT;
          end
        end
        S_POST_XOR: begin
          chain     <= blk;
          out_data  <= aluLo;
          out_valid <= 1'b1;
          out_last  <= (remaining == NB_W'(1));
          state     <= S_OUTPUT;
        end
        S_OUTPUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            remaining <= remaining - NB_W'(1);
            if (remaining == NB_W'(1)) begin
              done  <= 1'b1;
              state <= S_FINISH;
            end else begin
              in_ready <= 1'b1;
              state    <= S_LOAD;
            end
          end
        end
        S_FINISH: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
